// File: rtl/wb_spi_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the SPI master's Wishbone slave
// port: round-robin grant held per cycle, plus a stalled-strobe watchdog.
//
// Parameters:
//   AW      address width
//   DW      data width (select width SW = DW/8 is derived)
//   TIMEOUT cycles a granted strobe may wait for ack/err (4..65535)
//
// Ports:
//   clk, wb_rst_n          clock, asynchronous active-low reset
//   m0_* / m1_*            master 0 (CPU data) / master 1 (crypto loader)
//                          cyc/stb/we/sel/adr/dat in, dat/ack/err out
//   s_*                    shared SPI slave port
//   gnt_o                  one-hot grant, 00 when nobody is granted
//   timeout_o              one-cycle pulse when the watchdog aborts
//
// Build option:
//   WB_ARB_FIXED_PRIO_EN   master 0 always wins a tie in IDLE
//                          (default: round-robin on the last grant)

module wb_spi_bus_arbiter #(
   parameter  int AW      = 8,
   parameter  int DW      = 32,
   parameter  int TIMEOUT = 64,
   localparam int SW      = DW / 8
) (
   input  logic          clk,
   input  logic          wb_rst_n,

   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [SW-1:0] m0_sel_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,

   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [SW-1:0] m1_sel_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,

   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [SW-1:0] s_sel_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,

   output logic [1:0]    gnt_o,
   output logic          timeout_o
);

   typedef enum logic [1:0] {
      IDLE,
      GNT0,
      GNT1,
      ABORT
   } state_t;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        abort_q, abort_d;
   logic [15:0] wd_q, wd_d;

   logic          req0, req1;
   logic          pick1;
   logic          granted;
   logic          gsel;
   logic          g_cyc, g_stb, g_we;
   logic [SW-1:0] g_sel;
   logic [AW-1:0] g_adr;
   logic [DW-1:0] g_dat;
   logic          resp;
   logic          fire;
   logic          abort_cyc;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   // Tie-break in IDLE. last_q == 1 means master 1 held the bus last,
   // so master 0 wins the next tie (and the first one after reset).
`ifdef WB_ARB_FIXED_PRIO_EN
   assign pick1 = req1 & ~req0;
`else
   assign pick1 = req1 & (~req0 | ~last_q);
`endif

   assign granted = (state_q == GNT0) || (state_q == GNT1);
   assign gsel    = (state_q == GNT1);

   // Request lines of whichever master currently holds the grant.
   always_comb begin
      g_cyc = 1'b0;
      g_stb = 1'b0;
      g_we  = 1'b0;
      g_sel = '0;
      g_adr = '0;
      g_dat = '0;
      if (granted) begin
         if (gsel) begin
            g_cyc = m1_cyc_i;
            g_stb = m1_stb_i;
            g_we  = m1_we_i;
            g_sel = m1_sel_i;
            g_adr = m1_adr_i;
            g_dat = m1_dat_i;
         end else begin
            g_cyc = m0_cyc_i;
            g_stb = m0_stb_i;
            g_we  = m0_we_i;
            g_sel = m0_sel_i;
            g_adr = m0_adr_i;
            g_dat = m0_dat_i;
         end
      end
   end

   // A slave response in the last allowed cycle beats the watchdog.
   assign resp = s_ack_i | s_err_i;
   assign fire = granted & g_stb & ~resp & (wd_q == WD_LAST);

   assign abort_cyc = abort_q ? m1_cyc_i : m0_cyc_i;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      abort_d = abort_q;
      wd_d    = '0;

      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = pick1 ? GNT1 : GNT0;
               last_d  = pick1;
            end
         end
         GNT0, GNT1: begin
            if (g_stb & ~resp & ~fire) begin
               wd_d = wd_q + 16'd1;
            end
            // A release in the firing cycle still returns to IDLE.
            if (!g_cyc) begin
               state_d = IDLE;
               wd_d    = '0;
            end else if (fire) begin
               state_d = ABORT;
               abort_d = gsel;
            end
         end
         ABORT: begin
            if (!abort_cyc) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         abort_q <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         abort_q <= abort_d;
         wd_q    <= wd_d;
      end
   end

   // Slave side: zero outside a grant; cyc/stb cut in the firing cycle.
   always_comb begin
      s_cyc_o = g_cyc & ~fire;
      s_stb_o = g_stb & ~fire;
      s_we_o  = g_we;
      s_sel_o = g_sel;
      s_adr_o = g_adr;
      s_dat_o = g_dat;
   end

   // Master side: only the granted master sees the slave response.
   always_comb begin
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      if (granted) begin
         if (gsel) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | fire;
         end else begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | fire;
         end
      end
   end

   assign gnt_o     = {state_q == GNT1, state_q == GNT0};
   assign timeout_o = fire;

endmodule
